// File: rtl/hyperbus_trans_arbiter.sv
// rtl/hyperbus_trans_arbiter.sv - round-robin arbiter sharing one HyperBus transfer path among requesters
module hyperbus_trans_arbiter #(
    parameter int  NumReq     = 2,
    parameter int  TransWidth = 64,
    parameter int  TxWidth    = 35,
    parameter int  RxWidth    = 34,
    localparam int IdxW       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumReq*TransWidth-1:0] req_trans_i,
    input  logic [NumReq-1:0]            req_write_i,
    input  logic [NumReq-1:0]            req_valid_i,
    output logic [NumReq-1:0]            req_ready_o,
    input  logic [NumReq*TxWidth-1:0]    req_tx_i,
    input  logic [NumReq-1:0]            req_tx_last_i,
    input  logic [NumReq-1:0]            req_tx_valid_i,
    output logic [NumReq-1:0]            req_tx_ready_o,
    output logic [RxWidth-1:0]           req_rx_o,
    output logic                         req_rx_last_o,
    output logic [NumReq-1:0]            req_rx_valid_o,
    input  logic [NumReq-1:0]            req_rx_ready_i,
    output logic                         req_b_error_o,
    output logic [NumReq-1:0]            req_b_valid_o,
    input  logic [NumReq-1:0]            req_b_ready_i,
    output logic [TransWidth-1:0]        trans_o,
    output logic                         trans_valid_o,
    input  logic                         trans_ready_i,
    output logic [TxWidth-1:0]           tx_o,
    output logic                         tx_last_o,
    output logic                         tx_valid_o,
    input  logic                         tx_ready_i,
    input  logic [RxWidth-1:0]           rx_i,
    input  logic                         rx_last_i,
    input  logic                         rx_valid_i,
    output logic                         rx_ready_o,
    input  logic                         b_error_i,
    input  logic                         b_valid_i,
    output logic                         b_ready_o,
    output logic                         busy_o,
    output logic [IdxW-1:0]              grant_o
);

    typedef enum logic [2:0] {IDLE, ISSUE, WDATA, WRESP, RDATA} state_e;

    state_e                state_q;
    logic [IdxW-1:0]       rr_ptr_q;
    logic [IdxW-1:0]       grant_q;
    logic [TransWidth-1:0] trans_q;
    logic                  write_q;

    logic [IdxW-1:0]       winner_d;
    logic                  found_d;
    logic [IdxW-1:0]       rr_ptr_d;
    int unsigned           search_idx;

    // Pointer for the next arbitration round: one past the requester just served.
    assign rr_ptr_d = (grant_q == IdxW'(NumReq - 1)) ? '0 : grant_q + 1'b1;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        found_d    = 1'b0;
        winner_d   = '0;
        search_idx = 0;
        for (int k = 0; k < NumReq; k++) begin
            search_idx = (int'(rr_ptr_q) + k) % NumReq;
            if (!found_d && req_valid_i[search_idx]) begin
                found_d  = 1'b1;
                winner_d = IdxW'(search_idx);
            end
        end
    end

    // Arbitration FSM; the grant is held until the data and response phases finish.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            trans_q  <= '0;
            write_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        trans_q <= req_trans_i[winner_d*TransWidth +: TransWidth];
                        write_q <= req_write_i[winner_d];
                        grant_q <= winner_d;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (trans_ready_i) begin
                        state_q <= write_q ? WDATA : RDATA;
                    end
                end
                WDATA: begin
                    if (tx_valid_o && tx_ready_i && tx_last_o) begin
                        state_q <= WRESP;
                    end
                end
                WRESP: begin
                    if (b_valid_i && b_ready_o) begin
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end
                end
                RDATA: begin
                    if (rx_valid_i && rx_ready_o && rx_last_i) begin
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Channel routing: only the phase owned by the current state is connected, to the granted requester only.
    always_comb begin
        req_ready_o    = '0;
        req_tx_ready_o = '0;
        req_rx_valid_o = '0;
        req_b_valid_o  = '0;
        tx_o           = '0;
        tx_last_o      = 1'b0;
        tx_valid_o     = 1'b0;
        rx_ready_o     = 1'b0;
        b_ready_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (found_d) begin
                    req_ready_o[winner_d] = 1'b1;
                end
            end
            WDATA: begin
                tx_o                    = req_tx_i[grant_q*TxWidth +: TxWidth];
                tx_last_o               = req_tx_last_i[grant_q];
                tx_valid_o              = req_tx_valid_i[grant_q];
                req_tx_ready_o[grant_q] = tx_ready_i;
            end
            WRESP: begin
                req_b_valid_o[grant_q] = b_valid_i;
                b_ready_o              = req_b_ready_i[grant_q];
            end
            RDATA: begin
                req_rx_valid_o[grant_q] = rx_valid_i;
                rx_ready_o              = req_rx_ready_i[grant_q];
            end
            default: ;
        endcase
    end

    assign trans_o       = trans_q;
    assign trans_valid_o = (state_q == ISSUE);
    assign busy_o        = (state_q != IDLE);
    assign grant_o       = grant_q;
    assign req_rx_o      = rx_i;
    assign req_rx_last_o = rx_last_i;
    assign req_b_error_o = b_error_i;

endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// tb/tb_hyperbus_trans_arbiter.sv - scoreboard bench for hyperbus_trans_arbiter
module tb_hyperbus_trans_arbiter;

    localparam int N  = 4;
    localparam int TW = 64;
    localparam int XW = 35;
    localparam int RW = 34;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N*TW-1:0] req_trans_i;
    logic [N-1:0]    req_write_i, req_valid_i, req_ready_o;
    logic [N*XW-1:0] req_tx_i;
    logic [N-1:0]    req_tx_last_i, req_tx_valid_i, req_tx_ready_o;
    logic [RW-1:0]   req_rx_o;
    logic            req_rx_last_o;
    logic [N-1:0]    req_rx_valid_o, req_rx_ready_i;
    logic            req_b_error_o;
    logic [N-1:0]    req_b_valid_o, req_b_ready_i;
    logic [TW-1:0]   trans_o;
    logic            trans_valid_o, trans_ready_i;
    logic [XW-1:0]   tx_o;
    logic            tx_last_o, tx_valid_o, tx_ready_i;
    logic [RW-1:0]   rx_i;
    logic            rx_last_i, rx_valid_i, rx_ready_o;
    logic            b_error_i, b_valid_i, b_ready_o;
    logic            busy_o;
    logic [1:0]      grant_o;

    hyperbus_trans_arbiter #(.NumReq(N), .TransWidth(TW), .TxWidth(XW), .RxWidth(RW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_trans_i(req_trans_i), .req_write_i(req_write_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_tx_i(req_tx_i), .req_tx_last_i(req_tx_last_i),
        .req_tx_valid_i(req_tx_valid_i), .req_tx_ready_o(req_tx_ready_o),
        .req_rx_o(req_rx_o), .req_rx_last_o(req_rx_last_o),
        .req_rx_valid_o(req_rx_valid_o), .req_rx_ready_i(req_rx_ready_i),
        .req_b_error_o(req_b_error_o), .req_b_valid_o(req_b_valid_o),
        .req_b_ready_i(req_b_ready_i),
        .trans_o(trans_o), .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i),
        .tx_o(tx_o), .tx_last_o(tx_last_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .rx_i(rx_i), .rx_last_i(rx_last_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .b_error_i(b_error_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .busy_o(busy_o), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          grant;
        logic [63:0] trans;
    } exp_t;

    exp_t          exp_q[$];
    logic [RW-1:0] rx_q[$];
    int            checks = 0;
    int            errors = 0;
    int            g;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XW-1:0] beat_data(input int lane, input int n);
        return {3'(lane), 32'hB000_0000 + 32'(n)};
    endfunction

    function automatic logic [TW-1:0] trans_of(input int lane, input int tag);
        return 64'hC0DE_0000_0000_0000 + 64'(lane) + 64'(tag) * 64'h100;
    endfunction

    task automatic request(input int lane, input bit wr, input int tag);
        exp_t e;
        req_trans_i[lane*TW +: TW] = trans_of(lane, tag);
        req_write_i[lane]          = wr;
        req_valid_i[lane]          = 1'b1;
        e.grant = lane;
        e.trans = trans_of(lane, tag);
        exp_q.push_back(e);
    endtask

    // Waits for the IDLE grant, checks it against the scoreboard, and completes ISSUE.
    task automatic accept_issue(input bit drop, output int gnt);
        exp_t e;
        int   t;
        t = 0;
        #1;
        while (req_ready_o == '0 && t < 20) begin
            step();
            #1;
            t++;
        end
        chk("accept_timeout", 64'(t < 20), 1);
        chk("sb_nonempty", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else begin e.grant = 0; e.trans = '0; end
        gnt = e.grant;
        chk("req_ready", req_ready_o, 4'b0001 << e.grant);
        chk("busy_idle", busy_o, 0);
        step();
        if (drop) req_valid_i[gnt] = 1'b0;
        #1;
        chk("trans_valid", trans_valid_o, 1);
        chk("trans_o", trans_o, e.trans);
        chk("grant_o", grant_o, e.grant);
        chk("ready_in_issue", req_ready_o, 0);
        trans_ready_i = 1'b1;
        step();
        trans_ready_i = 1'b0;
    endtask

    task automatic write_data(input int gnt, input int beats, input bit toggle, input bit berr);
        int         n, cyc;
        logic [3:0] oh;
        oh = 4'b0001 << gnt;
        n = 0;
        cyc = 0;
        b_valid_i = 1'b1;
        b_error_i = 1'b1;
        req_b_ready_i = 4'hF;
        while (n < beats && cyc < 40) begin
            for (int i = 0; i < N; i++) req_tx_i[i*XW +: XW] = beat_data(i, n);
            req_tx_valid_i = 4'hF;
            req_tx_last_i  = (n == beats - 1) ? 4'hF : 4'h0;
            tx_ready_i     = toggle ? cyc[0] : 1'b1;
            #1;
            chk("tx_o", tx_o, beat_data(gnt, n));
            chk("tx_valid", tx_valid_o, 1);
            chk("tx_last", tx_last_o, 64'(n == beats - 1));
            chk("tx_ready_lanes", req_tx_ready_o, tx_ready_i ? oh : 4'h0);
            chk("b_gated_wdata", {b_ready_o, req_b_valid_o}, 0);
            if (tx_ready_i) n++;
            cyc++;
            step();
        end
        chk("tx_beats", n, beats);
        req_tx_valid_i = '0;
        req_tx_last_i  = '0;
        tx_ready_i     = 1'b0;
        b_error_i      = berr;
        req_b_ready_i  = oh;
        #1;
        chk("b_valid", req_b_valid_o, oh);
        chk("b_error", req_b_error_o, berr);
        chk("b_ready", b_ready_o, 1);
        chk("tx_gated_wresp", {tx_valid_o, req_tx_ready_o}, 0);
        step();
        b_valid_i     = 1'b0;
        b_error_i     = 1'b0;
        req_b_ready_i = '0;
        #1;
        chk("busy_after_b", busy_o, 0);
    endtask

    task automatic read_data(input int gnt, input int beats, input int err_beat);
        logic [3:0]    oh;
        logic [RW-1:0] v;
        oh = 4'b0001 << gnt;
        for (int n = 0; n < beats; n++) begin
            v = {32'hD00D_0000 + 32'(n), (n == err_beat), 1'b0};
            rx_i           = v;
            rx_last_i      = (n == beats - 1);
            rx_valid_i     = 1'b1;
            req_rx_ready_i = oh;
            rx_q.push_back(v);
            #1;
            chk("rx_valid", req_rx_valid_o, oh);
            chk("rx_ready", rx_ready_o, 1);
            chk("rx_last", req_rx_last_o, 64'(n == beats - 1));
            chk("busy_rdata", busy_o, 1);
            if (req_rx_valid_o[gnt]) chk("rx_data", req_rx_o, rx_q.pop_front());
            step();
        end
        rx_valid_i     = 1'b0;
        rx_last_i      = 1'b0;
        req_rx_ready_i = '0;
        #1;
        chk("busy_after_rx", busy_o, 0);
        chk("rx_sb_empty", rx_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        req_trans_i = '0; req_write_i = '0; req_valid_i = '0;
        req_tx_i = '0; req_tx_last_i = '0; req_tx_valid_i = '0;
        req_rx_ready_i = '0; req_b_ready_i = '0;
        trans_ready_i = 1'b0; tx_ready_i = 1'b0;
        rx_i = '0; rx_last_i = 1'b0; rx_valid_i = 1'b0;
        b_error_i = 1'b0; b_valid_i = 1'b0;
        step();
        step();
        chk("rst_busy", busy_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_trans", trans_o, 0);
        chk("rst_valids", {trans_valid_o, tx_valid_o, rx_ready_o, b_ready_o, req_ready_o}, 0);
        rst_i = 1'b0;

        // Fairness: all requesters continuously valid with single-beat writes.
        for (int i = 0; i < N; i++) request(i, 1'b1, 0);
        request(0, 1'b1, 0);
        for (int k = 0; k < 5; k++) begin
            accept_issue(1'b0, g);
            write_data(g, 1, 1'b0, 1'b0);
        end
        req_valid_i = '0;

        // Lone read from requester 2, error flagged on beat 2 of 4.
        request(2, 1'b0, 1);
        accept_issue(1'b1, g);
        read_data(g, 4, 1);
        chk("grant_after_read", grant_o, 2);

        // 3-beat write from requester 0 with tx_ready toggling and an error response.
        request(0, 1'b1, 2);
        accept_issue(1'b1, g);
        write_data(g, 3, 1'b1, 1'b1);

        // Single-beat read from requester 1 moves the pointer to 2.
        request(1, 1'b0, 3);
        accept_issue(1'b1, g);
        read_data(g, 1, -1);

        // Reset while requester 2 is in its write data phase.
        request(2, 1'b1, 4);
        accept_issue(1'b1, g);
        req_tx_i[2*XW +: XW] = beat_data(2, 0);
        req_tx_valid_i = 4'b0100;
        tx_ready_i = 1'b1;
        #1;
        chk("pre_rst_tx_valid", tx_valid_o, 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        req_tx_valid_i = '0;
        tx_ready_i = 1'b0;
        #1;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_grant", grant_o, 0);
        chk("midrst_trans", trans_o, 0);
        chk("midrst_valids", {trans_valid_o, tx_valid_o, rx_ready_o, b_ready_o, req_ready_o,
                              req_tx_ready_o, req_rx_valid_o, req_b_valid_o}, 0);

        // After reset the search restarts at 0, so 1 wins over 3, then 3 follows.
        request(1, 1'b0, 5);
        request(3, 1'b0, 6);
        accept_issue(1'b1, g);
        read_data(g, 1, -1);
        accept_issue(1'b1, g);
        read_data(g, 2, -1);

        chk("exp_sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
